// File: rtl/pipelined_functional_unit.sv
// Fully pipelined integer functional unit with a fixed issue-to-result latency.
// One op per cycle is accepted; results leave in issue order towards either the
// wakeup bus or the LSQ address bus, each broadcast qualified by the CDB grant.
//
// Optional feature macro: FU_FLUSH_EN adds the 'flush' input, which drops every
// in-flight op (and any op issued in the same cycle).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   issue_valid/ready     issue handshake from the RS select logic
//   alu_ctrl, alu_src     opcode and rhs select (0: rs2_value, 1: imm)
//   is_for_lsq            route result to the LSQ bus instead of wakeup
//   imm, rs1_value, rs2_value, tag_in, rob_in   operands and destination ids
//   out_req / out_grant   result request to, and grant from, the CDB arbiter
//   wakeup_*              wakeup broadcast (active only in granted cycle)
//   lsq_wakeup_*          LSQ broadcast (active only in granted cycle)
//   occupancy             number of valid stages in flight
//   flush                 (FU_FLUSH_EN only) invalidate all stages
module pipelined_functional_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned ROB_W   = 6,
  parameter int unsigned LATENCY = 3,
  localparam int unsigned OCC_W  = $clog2(LATENCY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic               alu_src,
  input  logic               is_for_lsq,
  input  logic [DATA_W-1:0]  imm,
  input  logic [DATA_W-1:0]  rs1_value,
  input  logic [DATA_W-1:0]  rs2_value,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic [ROB_W-1:0]   rob_in,
  output logic               out_req,
  input  logic               out_grant,
  output logic               wakeup_active,
  output logic [TAG_W-1:0]   wakeup_tag,
  output logic [ROB_W-1:0]   wakeup_rob_index,
  output logic [DATA_W-1:0]  wakeup_value,
  output logic               lsq_wakeup_active,
  output logic [ROB_W-1:0]   lsq_wakeup_rob_index,
  output logic [DATA_W-1:0]  lsq_wakeup_value,
`ifdef FU_FLUSH_EN
  input  logic               flush,
`endif
  output logic [OCC_W-1:0]   occupancy
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned LAST = LATENCY - 1;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] lsq_q;
  logic [DATA_W-1:0]  val_q [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [ROB_W-1:0]   rob_q [LATENCY];
  logic [OCC_W-1:0]   occ_q;

  logic [DATA_W-1:0]  rhs;
  logic [DATA_W-1:0]  result;
  logic               op_illegal;
  logic               advance;
  logic               accept;
  logic               pop;
  logic               flush_int;

`ifdef FU_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  // Result is computed at issue; the stages only carry it to the fixed latency.
  always_comb begin
    rhs        = alu_src ? imm : rs2_value;
    op_illegal = 1'b0;
    case (alu_ctrl)
      4'b0001: result = rs1_value | rhs;
      4'b0010: result = rs1_value + rhs;
      4'b0011: result = rs1_value ^ rhs;
      4'b0100: result = rs1_value - rhs;
      4'b0101: result = rs1_value & rhs;
      4'b1001: result = rs1_value << rhs[SH_W-1:0];
      4'b1010: result = rs1_value >> rhs[SH_W-1:0];
      4'b1011: result = DATA_W'($signed(rs1_value) >>> rhs[SH_W-1:0]);
      4'b1100: result = rhs;
      4'b0000, 4'b1111: result = '1;
      default: begin
        result     = '1;
        op_illegal = 1'b1;
      end
    endcase
  end

  assign out_req     = vld_q[LAST];
  assign advance     = !out_req || out_grant;
  assign issue_ready = advance;
  assign accept      = issue_valid && advance;
  assign pop         = out_req && out_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      lsq_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
        rob_q[i] <= '0;
      end
    end else if (flush_int) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      if (advance) begin
        // Bubbles shift along with ops so every op sees exactly LATENCY stages.
        for (int i = LATENCY - 1; i > 0; i--) begin
          vld_q[i] <= vld_q[i-1];
          lsq_q[i] <= lsq_q[i-1];
          val_q[i] <= val_q[i-1];
          tag_q[i] <= tag_q[i-1];
          rob_q[i] <= rob_q[i-1];
        end
        vld_q[0] <= accept;
        lsq_q[0] <= is_for_lsq;
        val_q[0] <= result;
        tag_q[0] <= tag_in;
        rob_q[0] <= rob_in;
      end
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy            = occ_q;
  assign wakeup_active        = pop && !lsq_q[LAST] && !flush_int;
  assign lsq_wakeup_active    = pop && lsq_q[LAST] && !flush_int;
  assign wakeup_tag           = tag_q[LAST];
  assign wakeup_rob_index     = rob_q[LAST];
  assign wakeup_value         = val_q[LAST];
  assign lsq_wakeup_rob_index = rob_q[LAST];
  assign lsq_wakeup_value     = val_q[LAST];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      if (accept && op_illegal) $error("illegal alu_ctrl %b accepted", alu_ctrl);
      if (out_grant && !out_req) $error("out_grant without out_req");
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_functional_unit.sv
module tb_pipelined_functional_unit;
  localparam int unsigned LATENCY = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  alu_ctrl = 4'd0;
  logic        alu_src = 1'b0;
  logic        is_for_lsq = 1'b0;
  logic [31:0] imm = '0, rs1_value = '0, rs2_value = '0;
  logic [5:0]  tag_in = '0, rob_in = '0;
  logic        out_req;
  logic        out_grant = 1'b0;
  logic        wakeup_active, lsq_wakeup_active;
  logic [5:0]  wakeup_tag, wakeup_rob_index, lsq_wakeup_rob_index;
  logic [31:0] wakeup_value, lsq_wakeup_value;
  logic [1:0]  occupancy;
  logic        flush = 1'b0;

  int checks = 0;
  int failures = 0;
  bit grant_en = 1'b1;
  logic [31:0] obs[$];

  pipelined_functional_unit #(.DATA_W(32), .TAG_W(6), .ROB_W(6), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .is_for_lsq(is_for_lsq), .imm(imm),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .tag_in(tag_in), .rob_in(rob_in),
    .out_req(out_req), .out_grant(out_grant), .wakeup_active(wakeup_active),
    .wakeup_tag(wakeup_tag), .wakeup_rob_index(wakeup_rob_index),
    .wakeup_value(wakeup_value), .lsq_wakeup_active(lsq_wakeup_active),
    .lsq_wakeup_rob_index(lsq_wakeup_rob_index), .lsq_wakeup_value(lsq_wakeup_value),
`ifdef FU_FLUSH_EN
    .flush(flush),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
    case (c)
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a - b;
      4'd5:    return a & b;
      4'd9:    return a << b[4:0];
      4'd10:   return a >> b[4:0];
      4'd11:   return $signed(a) >>> b[4:0];
      4'd12:   return b;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Model: in-order list of ops, each with the number of pipeline moves it has seen.
  typedef struct {
    logic [31:0] val;
    logic [5:0]  tag;
    logic [5:0]  rob;
    logic        lsq;
    int          age;
  } ent_t;
  ent_t q[$];

  function automatic bit m_req();
    return q.size() > 0 && q[0].age == LATENCY - 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      bit req;
      req = m_req();
      if (!req || out_grant) begin
        if (req) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (issue_valid)
          q.push_back('{alu(alu_ctrl, rs1_value, alu_src ? imm : rs2_value),
                        tag_in, rob_in, is_for_lsq, 0});
      end
    end
  end

  // Grant only what is requested, so the arbiter contract is respected.
  always @(posedge clk) begin
    #2;
    out_grant = m_req() && grant_en;
  end

  always @(negedge clk) begin
    if (reset) begin
      check("rst_out_req", out_req, 0);
      check("rst_occ", occupancy, 0);
      check("rst_active", {wakeup_active, lsq_wakeup_active}, 0);
      check("rst_outs", {wakeup_tag, wakeup_rob_index, wakeup_value}, 0);
    end else begin
      bit req;
      req = m_req();
      check("ready", issue_ready, !req || out_grant);
      check("out_req", out_req, req);
      check("occupancy", occupancy, q.size());
      check("wk_active", wakeup_active, req && out_grant && !q[0].lsq && !flush);
      check("lsq_active", lsq_wakeup_active, req && out_grant && q[0].lsq && !flush);
      if (req) begin
        check("wk_value", wakeup_value, q[0].val);
        check("wk_tag", wakeup_tag, q[0].tag);
        check("wk_rob", wakeup_rob_index, q[0].rob);
        check("lsq_value", lsq_wakeup_value, q[0].val);
        check("lsq_rob", lsq_wakeup_rob_index, q[0].rob);
      end
      if (wakeup_active) obs.push_back(wakeup_value);
      if (lsq_wakeup_active) obs.push_back(lsq_wakeup_value);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic src, input logic lsq, input logic [5:0] t,
                        input logic [5:0] r);
    issue_valid = 1'b1;
    alu_ctrl = c;
    rs1_value = a;
    rs2_value = src ? 32'h0 : b;
    imm = src ? b : 32'h0;
    alu_src = src;
    is_for_lsq = lsq;
    tag_in = t;
    rob_in = r;
  endtask

  localparam logic [3:0] OPS [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10,
                                      4'd11, 4'd12, 4'd15};

  initial begin
    int n;
    // Pin the model's arithmetic with hand-computed values.
    check("pin_add", alu(4'd2, 32'd5, 32'd7), 32'd12);
    check("pin_sra", alu(4'd11, 32'h8000_0000, 32'd4), 32'hF800_0000);
    check("pin_sub", alu(4'd4, 32'd3, 32'd10), 32'hFFFF_FFF9);
    check("pin_none", alu(4'd15, 32'd1, 32'd2), 32'hFFFF_FFFF);

    cyc(2);
    reset = 1'b0;
    cyc();

    // Test 1: ADD 5+7, broadcast on the third cycle after acceptance.
    grant_en = 1'b1;
    set_op(4'd2, 32'd5, 32'd7, 1'b0, 1'b0, 6'd3, 6'd9);
    cyc();
    issue_valid = 1'b0;
    @(negedge clk) check("t1_c1_active", wakeup_active, 0);
    @(negedge clk) check("t1_c2_active", wakeup_active, 0);
    @(negedge clk);
    check("t1_active", wakeup_active, 1);
    check("t1_value", wakeup_value, 32'd12);
    check("t1_tag_rob", {wakeup_tag, wakeup_rob_index}, {6'd3, 6'd9});
    cyc(2);

    // Test 2: four back-to-back ops give four consecutive results.
    set_op(4'd1, 32'hF0, 32'h0F, 1'b0, 1'b0, 6'd1, 6'd1);
    cyc();
    set_op(4'd3, 32'hFF, 32'h0F, 1'b0, 1'b0, 6'd2, 6'd2);
    cyc();
    set_op(4'd4, 32'd10, 32'd3, 1'b0, 1'b0, 6'd3, 6'd3);
    cyc();
    set_op(4'd11, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 6'd4, 6'd4);
    cyc();
    issue_valid = 1'b0;
    cyc(5);
    n = obs.size();
    check("t2_or", obs[n-4], 32'hFF);
    check("t2_xor", obs[n-3], 32'hF0);
    check("t2_sub", obs[n-2], 32'd7);
    check("t2_sra", obs[n-1], 32'hF800_0000);

    // Test 3: stall three ops for five cycles, then drain in order.
    grant_en = 1'b0;
    set_op(4'd2, 32'd100, 32'd1, 1'b0, 1'b0, 6'd5, 6'd5);
    cyc();
    set_op(4'd2, 32'd200, 32'd2, 1'b0, 1'b0, 6'd6, 6'd6);
    cyc();
    set_op(4'd2, 32'd300, 32'd3, 1'b0, 1'b0, 6'd7, 6'd7);
    cyc();
    set_op(4'd12, 32'd0, 32'd999, 1'b1, 1'b0, 6'd8, 6'd8);
    cyc(4);
    issue_valid = 1'b0;
    cyc();
    @(negedge clk);
    check("t3_req", out_req, 1);
    check("t3_ready", issue_ready, 0);
    check("t3_occ", occupancy, 3);
    n = obs.size();
    grant_en = 1'b1;
    cyc(5);
    check("t3_count", obs.size() - n, 3);
    check("t3_r0", obs[n], 32'd101);
    check("t3_r1", obs[n+1], 32'd202);
    check("t3_r2", obs[n+2], 32'd303);

    // Test 4: address computation routed to the LSQ bus.
    set_op(4'd2, 32'h1000, 32'h10, 1'b1, 1'b1, 6'd10, 6'd11);
    cyc();
    issue_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t4_lsq_active", lsq_wakeup_active, 1);
    check("t4_wk_active", wakeup_active, 0);
    check("t4_value", lsq_wakeup_value, 32'h1010);
    check("t4_rob", lsq_wakeup_rob_index, 6'd11);
    cyc(2);

    // Test 5: reset with two ops in flight discards them.
    set_op(4'd2, 32'd1, 32'd1, 1'b0, 1'b0, 6'd1, 6'd1);
    cyc();
    set_op(4'd2, 32'd2, 32'd2, 1'b0, 1'b0, 6'd2, 6'd2);
    cyc();
    issue_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t5_req", out_req, 0);
    check("t5_occ", occupancy, 0);
    n = obs.size();
    cyc(2);
    reset = 1'b0;
    cyc(5);
    check("t5_no_bcast", obs.size(), n);

`ifdef FU_FLUSH_EN
    // Test 6: flush with three in flight plus a same-cycle issue.
    grant_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(4'd2, i, 32'd1, 1'b0, 1'b0, 6'(i), 6'(i));
      cyc();
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    issue_valid = 1'b0;
    grant_en = 1'b1;
    @(negedge clk) check("t6_occ", occupancy, 0);
    n = obs.size();
    cyc(5);
    check("t6_no_bcast", obs.size(), n);
`endif

    // Random phase against the model.
    for (int i = 0; i < 600; i++) begin
      grant_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7)
        set_op(OPS[$urandom_range(0, 10)], $urandom(),
               ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               6'($urandom()), 6'($urandom()));
      else
        issue_valid = 1'b0;
      cyc();
    end
    issue_valid = 1'b0;
    grant_en = 1'b1;
    cyc(LATENCY + 3);
    @(negedge clk) check("final_drained", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
